// File: rtl/ps2_key_event_filter_if.sv
// Key-event handshake bus between the PS/2 event filter and its consumer.
// The master side presents the queued head event and the slave side accepts it with key_ready.
interface ps2_key_event_filter_if;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_ext, output key_valid, input key_ready);
  modport slave  (input key_code, input key_ext, input key_valid, output key_ready);
endinterface

// File: rtl/ps2_key_event_filter.sv
// Turns a PS/2 Set-2 scancode byte stream into de-duplicated key-press events,
// queued in a small first-word-fall-through FIFO behind a valid/ready handshake.
module ps2_key_event_filter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  ps2_key_event_filter_if.master        key_bus,
  output logic [7:0]                    held_code,
  output logic                          held_ext,
  output logic                          overflow
);

  typedef enum logic [1:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t state_reg, state_next;

  logic       make_req, make_ext;
  logic       release_req, release_ext;
  logic       is_prefix, is_filtered;
  logic       is_repeat, push, pop, full, do_write;

  logic [7:0] held_code_reg;
  logic       held_ext_reg;
  logic       overflow_reg;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_reg, rd_reg;
  logic [ADDR_W:0]   count_reg;
  logic [8:0]        head;

  assign is_prefix   = (rx_data == 8'hE0) || (rx_data == 8'hF0);
  assign is_filtered = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hEE) ||
                       (rx_data == 8'hFE) || (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= S_BASE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    make_req    = 1'b0;
    make_ext    = 1'b0;
    release_req = 1'b0;
    release_ext = 1'b0;
    if (rx_valid) begin
      case (state_reg)
        S_BASE: begin
          if (rx_data == 8'hE0)      state_next = S_EXT;
          else if (rx_data == 8'hF0) state_next = S_BRK;
          else if (!is_filtered)     make_req   = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) state_next = S_EXT_BRK;
          else if (rx_data != 8'hE0) begin
            make_req   = 1'b1;
            make_ext   = 1'b1;
            state_next = S_BASE;
          end
        end
        default: begin
          // A prefix byte where a break code was expected is a protocol error and is discarded.
          state_next  = S_BASE;
          release_req = !is_prefix;
          release_ext = (state_reg == S_EXT_BRK);
        end
      endcase
    end
  end

  assign is_repeat = (rx_data == held_code_reg) && (make_ext == held_ext_reg);
  assign push      = make_req && !is_repeat;
  assign pop       = (count_reg != '0) && key_bus.key_ready;
  assign full      = (count_reg == (ADDR_W+1)'(FIFO_DEPTH));
  assign do_write  = push && (!full || pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_code_reg <= 8'h00;
      held_ext_reg  <= 1'b0;
    end else if (push) begin
      held_code_reg <= rx_data;
      held_ext_reg  <= make_ext;
    end else if (release_req && rx_data == held_code_reg && release_ext == held_ext_reg) begin
      held_code_reg <= 8'h00;
      held_ext_reg  <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_write) mem[wr_reg] <= {make_ext, rx_data};
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_reg       <= '0;
      rd_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_write) wr_reg <= wr_reg + ADDR_W'(1);
      if (pop)      rd_reg <= rd_reg + ADDR_W'(1);
      case ({do_write, pop})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Storage contents are undefined when empty, so the head is masked off rather than cleared.
  assign head              = mem[rd_reg];
  assign key_bus.key_valid = (count_reg != '0);
  assign key_bus.key_code  = key_bus.key_valid ? head[7:0] : 8'h00;
  assign key_bus.key_ext   = key_bus.key_valid ? head[8]   : 1'b0;

  assign held_code = held_code_reg;
  assign held_ext  = held_ext_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_filter.sv
// Randomised and directed bench for ps2_key_event_filter against a queue-based event model.
module tb_ps2_key_event_filter;

  localparam int DEPTH = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] held_code;
  logic       held_ext;
  logic       overflow;

  ps2_key_event_filter_if bus ();

  ps2_key_event_filter #(.FIFO_DEPTH(DEPTH), .ADDR_W(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_bus   (bus.master),
    .held_code (held_code),
    .held_ext  (held_ext),
    .overflow  (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a byte-level decoder with pending-prefix flags and an event queue.
  logic [8:0] m_q[$];
  logic [7:0] m_held;
  logic       m_hext;
  logic       m_ovf;
  bit         m_pend_ext;
  bit         m_pend_brk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_held = 8'h00;
    m_hext = 1'b0;
    m_ovf = 1'b0;
    m_pend_ext = 0;
    m_pend_brk = 0;
  endtask

  function automatic bit ignored_byte(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  task automatic model_edge(input logic valid, input logic [7:0] b, input logic ready);
    bit was_ext;
    bit do_pop;
    int size_before;
    size_before = m_q.size();
    do_pop = (size_before > 0) && ready;
    if (do_pop) void'(m_q.pop_front());
    if (valid) begin
      if (m_pend_brk) begin
        was_ext = m_pend_ext;
        m_pend_brk = 0;
        m_pend_ext = 0;
        if (b != 8'hE0 && b != 8'hF0 && b == m_held && was_ext == m_hext) begin
          m_held = 8'h00;
          m_hext = 1'b0;
        end
      end else if (b == 8'hF0) begin
        m_pend_brk = 1;
      end else if (b == 8'hE0) begin
        m_pend_ext = 1;
      end else if (!m_pend_ext && ignored_byte(b)) begin
        // dropped
      end else begin
        was_ext = m_pend_ext;
        m_pend_ext = 0;
        if (!(b == m_held && was_ext == m_hext)) begin
          m_held = b;
          m_hext = was_ext;
          if (size_before == DEPTH && !do_pop) m_ovf = 1'b1;
          else m_q.push_back({was_ext, b});
        end
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [8:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 9'h000;
    check({ctx, ".key_valid"}, 32'(bus.key_valid), 32'(m_q.size() > 0));
    check({ctx, ".key_code"},  32'(bus.key_code),  32'(hd[7:0]));
    check({ctx, ".key_ext"},   32'(bus.key_ext),   32'(hd[8]));
    check({ctx, ".held_code"}, 32'(held_code),     32'(m_held));
    check({ctx, ".held_ext"},  32'(held_ext),      32'(m_hext));
    check({ctx, ".overflow"},  32'(overflow),      32'(m_ovf));
  endtask

  // Called 1 time unit after a rising edge; drives one cycle and checks just after its closing edge.
  task automatic tick(input logic valid, input logic [7:0] b, input logic ready, input string ctx);
    rx_valid = valid;
    rx_data = b;
    bus.key_ready = ready;
    model_edge(valid, b, ready);
    @(posedge CLOCK_50);
    #1;
    rx_valid = 1'b0;
    if (valid)
      $display("byte %02h ready=%0b -> valid=%0b code=%02h ext=%0b held=%02h/%0b ovf=%0b",
               b, ready, bus.key_valid, bus.key_code, bus.key_ext, held_code, held_ext, overflow);
    check_outputs(ctx);
  endtask

  task automatic send(input logic [7:0] b, input logic ready, input string ctx);
    tick(1'b1, b, ready, ctx);
  endtask

  // Asynchronous reset in mid-cycle; a byte presented across the reset edge must be ignored.
  task automatic pulse_reset(input string ctx);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs({ctx, ".async"});
    rx_valid = 1'b1;
    rx_data = 8'h75;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    rx_valid = 1'b0;
    check_outputs({ctx, ".release"});
  endtask

  logic [7:0] tab [12] = '{8'h1C, 8'h32, 8'h75, 8'h15, 8'hE0, 8'hF0,
                           8'hF0, 8'hAA, 8'h1C, 8'h6B, 8'hE0, 8'h00};

  initial begin
    bus.key_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // Simple press/release
    send(8'h1C, 1'b0, "press");
    check("press.held", 32'(held_code), 32'h1C);
    send(8'hF0, 1'b1, "press.brk");
    send(8'h1C, 1'b1, "press.rel");
    check("press.held_clr", 32'(held_code), 32'h00);
    tick(1'b0, 8'h00, 1'b1, "press.idle");

    // Extended key
    send(8'hE0, 1'b0, "ext.pfx");
    send(8'h75, 1'b0, "ext.make");
    check("ext.event_ext", 32'(bus.key_ext), 32'h1);
    send(8'hE0, 1'b0, "ext.pfx2");
    send(8'hF0, 1'b0, "ext.brk");
    send(8'h75, 1'b0, "ext.rel");
    tick(1'b0, 8'h00, 1'b1, "ext.pop");
    tick(1'b0, 8'h00, 1'b1, "ext.empty");

    // Typematic then new key
    for (int i = 0; i < 5; i++) send(8'h1C, 1'b0, "typ.rep");
    send(8'h32, 1'b0, "typ.new");
    check("typ.held", 32'(held_code), 32'h32);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1, "typ.drain");

    // Overflow
    send(8'h15, 1'b0, "ovf.a");
    send(8'h1D, 1'b0, "ovf.b");
    send(8'h24, 1'b0, "ovf.c");
    send(8'h2D, 1'b0, "ovf.d");
    send(8'h2C, 1'b0, "ovf.e");
    check("ovf.flag", 32'(overflow), 32'h1);
    check("ovf.head", 32'(bus.key_code), 32'h15);
    check("ovf.held", 32'(held_code), 32'h2C);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b1, "ovf.drain");

    // Full with simultaneous pop
    pulse_reset("rst1");
    send(8'h16, 1'b0, "fp.a");
    send(8'h1E, 1'b0, "fp.b");
    send(8'h26, 1'b0, "fp.c");
    send(8'h25, 1'b0, "fp.d");
    send(8'h35, 1'b1, "fp.push_pop");
    check("fp.no_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b1, "fp.drain");

    // Filtered bytes and mid-prefix reset
    send(8'hAA, 1'b0, "flt.aa");
    send(8'hFA, 1'b0, "flt.fa");
    send(8'hE0, 1'b0, "mid.pfx");
    pulse_reset("rst2");
    send(8'h75, 1'b0, "mid.make");
    check("mid.ext_cleared", 32'(bus.key_ext), 32'h0);
    check("mid.code", 32'(bus.key_code), 32'h75);

    // Randomised traffic, including back-to-back bytes and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 3) == 0) b = 8'($urandom);
      else b = tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 149) == 0) pulse_reset("rnd.rst");
      else tick(logic'($urandom_range(0, 9) < 7), b, logic'($urandom_range(0, 2) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_filter.md
# ps2_key_event_filter

Sits directly downstream of `PS2_Controller`, in place of the raw "latch last byte" register. It turns the PS/2 Set-2 scancode byte stream into clean key-press events:
- strips `F0` break and `E0` extended prefixes;
- suppresses typematic auto-repeat;
- queues make events in a small FIFO with a valid/ready handshake, which feeds the letter-decoding logic.

## Interface
- `FIFO_DEPTH`, default 4: event queue depth; power of 2, minimum 2.
- `ADDR_W`, default 2: log2(`FIFO_DEPTH`).

- `CLOCK_50` input 1: sole clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rx_data` input 8: byte from `PS2_Controller` `received_data`.
- `rx_valid` input 1: one-cycle strobe from `received_data_en`; `rx_data` is valid only in that cycle.
- `key_code` output 8: make code at FIFO head; `8'h00` when `key_valid`=0.
- `key_ext` output 1: head event was `E0`-prefixed; 0 when `key_valid`=0.
- `key_valid` output 1: FIFO non-empty.
- `key_ready` input 1: consumer accepts the head event when `key_valid` and `key_ready` are both high on a clock edge.
- `held_code` output 8: make code of the key currently held, `8'h00` if none.
- `held_ext` output 1: extended flag of the held key.
- `overflow` output 1: sticky; set when an event is dropped because the FIFO is full; cleared only by `reset`.

## Operation
- **Reset values:** FSM=`S_BASE`, FIFO empty (pointers 0, count 0), `key_valid`=0, `key_code`=00, `key_ext`=0, `held_code`=00, `held_ext`=0, `overflow`=0.
- The FSM advances only in cycles with `rx_valid`=1.
- **`S_BASE`:**
  - `E0` → `S_EXT`.
  - `F0` → `S_BRK`.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF` are dropped; the state is unchanged.
  - Any other byte b is a make with ext=0.
- **`S_EXT`:**
  - `F0` → `S_EXT_BRK`.
  - `E0` → stay in `S_EXT`.
  - Any other byte b is a make with ext=1, then → `S_BASE`.
- **`S_BRK` / `S_EXT_BRK`:**
  - Byte b is a release with ext=0 or ext=1 respectively, then → `S_BASE`.
  - If b equals `held_code` and the ext flag matches `held_ext`: `held_code`←00, `held_ext`←0. Otherwise held state is unchanged.
  - If b is `E0` or `F0`: protocol error; drop the byte, go to `S_BASE`, held state unchanged.
- **Make handling:**
  - If (b, ext) equals (`held_code`, `held_ext`), the make is a typematic repeat and is dropped.
  - Otherwise push (b, ext) into the FIFO and set `held_code`←b, `held_ext`←ext.
  - A new key pressed while another is held therefore replaces the held key.
- **FIFO:** 9-bit entries (ext, code), first-word-fall-through. The head is visible combinationally from storage at the read pointer. Pointers are `ADDR_W` bits and wrap modulo `FIFO_DEPTH`. Count is `ADDR_W`+1 bits.
- **Pop:** occurs when `key_valid` & `key_ready`. A pop while empty is impossible because `key_valid`=0.
- **Push when full:**
  - Without a same-cycle pop: the new event is dropped, `overflow`←1, and `held_code` is still updated.
  - With a same-cycle pop: both occur and the count is unchanged.
- **Push when empty with `key_ready`=1:** no bypass; the event appears next cycle.

## Timing
- A byte with `rx_valid` in cycle N causes the following at the edge ending cycle N:
  - the FSM state update;
  - the `held_*` update;
  - the FIFO write.
- The resulting event is therefore visible on `key_valid`/`key_code` in cycle N+1 (latency 1).
- `key_code`, `key_ext` and `key_valid` are stable while `key_ready`=0.
- A pop at edge E exposes the next entry, or 00/`key_valid`=0 if the FIFO is now empty, immediately after E.
- Back-to-back `rx_valid` on consecutive cycles is supported (the PS/2 rate never does this, but the bench does).
- Reset asserted mid-prefix or mid-queue takes effect immediately and asynchronously:
  - all outputs return to reset values;
  - a byte arriving in the reset-release cycle is ignored.
- `overflow` rises the cycle after the dropping edge.

## Test plan
- **Simple press/release:** `1C`, `F0`, `1C` with `key_ready`=1 → one event `key_code`=1C, `key_ext`=0 at N+1. `held_code`=1C after the first byte, 00 after the last.
- **Extended key:** `E0`, `75`, `E0`, `F0`, `75` → one event 75 with `key_ext`=1. `held_ext` is 1 then 0. No event is produced for the release.
- **Typematic and new key:** `1C` ×5 then `32` → exactly two events, 1C then 32. `held_code`=32.
- **Overflow:** `key_ready`=0; push 5 distinct makes (`15`, `1D`, `24`, `2D`, `2C`) → 4 queued, `overflow`=1. Draining yields 15, 1D, 24, 2D in order, then `key_valid`=0.
- **Full with simultaneous pop:** FIFO full, `key_ready`=1 in the same cycle as a new make `35` → `overflow` stays 0, count stays 4, and `35` emerges last.
- **Mid-sequence reset / filtered bytes:** `AA`, `FA` in `S_BASE` → no event. Then `E0`, reset pulse, then `75` → event 75 with `key_ext`=0 (prefix cleared).
